// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, defaults and width helpers for the TX FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int unsigned DATA_W_DEF        = 64;
  localparam int unsigned MAX_PKT_WORDS_DEF = 112;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

  // Source-id width, never narrower than one bit so a single source still has a port.
  function automatic int unsigned id_width(input int unsigned num_src);
    return (clog2(num_src) == 0) ? 1 : clog2(num_src);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  localparam int unsigned ID_W   = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  // First pass covers indices above last, second pass wraps around to 0..last.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!any && req[i] && (i > int'(last))) begin
        any    = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one show-ahead FIFO write port
// between NUM_SRC streaming sources; grants start only below almost-full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned MAX_PKT_WORDS = MAX_PKT_WORDS_DEF,
  parameter int unsigned CNT_W         = 16,
  localparam int unsigned ID_W         = id_width(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic [NUM_SRC*DATA_W-1:0]  s_data,
  input  logic [NUM_SRC-1:0]         s_valid,
  input  logic [NUM_SRC-1:0]         s_last,
  output logic [NUM_SRC-1:0]         s_ready,
  output logic [DATA_W-1:0]          fifo_din,
  output logic                       fifo_wr_en,
  input  logic                       fifo_full,
  input  logic                       fifo_prog_full,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       oversize_err,
  output logic [NUM_SRC*CNT_W-1:0]   pkt_count
);

  localparam int unsigned     WC_W   = clog2(MAX_PKT_WORDS + 2);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_PKT_WORDS);
  localparam logic [WC_W-1:0] WC_SAT = WC_W'(MAX_PKT_WORDS + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_d;
  logic [ID_W-1:0]  last_grant, last_d;
  logic [WC_W-1:0]  word_cnt, wc_d;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req    (s_valid),
    .last   (last_grant),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Steer the granted source's beat, last flag and valid onto the FIFO side.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*int'(DATA_W) +: DATA_W];
      end
    end
  end

  // Next-state and handshake logic; srst_n gates the handshake so reset kills writes at once.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_id;
    last_d     = last_grant;
    wc_d       = word_cnt;
    err_d      = oversize_err;
    cnt_d      = cnt_q;
    s_ready    = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = sel_data;

    case (state_q)
      IDLE: begin
        if (pick_any && !fifo_prog_full) begin
          grant_d = pick_id;
          state_d = XFER;
        end
      end

      XFER: begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
          s_ready[i] = srst_n && !fifo_full && (grant_id == ID_W'(i));
        end
        fifo_wr_en = srst_n && !fifo_full && sel_valid;

        if (fifo_wr_en) begin
          if (word_cnt != WC_SAT) wc_d = word_cnt + WC_W'(1);
          if ((word_cnt == WC_MAX) && !sel_last) err_d = 1'b1;
          if (sel_last) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
              if (grant_id == ID_W'(i)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            last_d  = grant_id;
            wc_d    = '0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q      <= IDLE;
      grant_id     <= '0;
      last_grant   <= ID_W'(NUM_SRC - 1);
      word_cnt     <= '0;
      oversize_err <= 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_id     <= grant_d;
      last_grant   <= last_d;
      word_cnt     <= wc_d;
      oversize_err <= err_d;
      for (int i = 0; i < int'(NUM_SRC); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy = (state_q == XFER);

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      pkt_count[i*int'(CNT_W) +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: source drivers feed queued beats,
// a monitor pops expected FIFO writes and grants as the DUT produces them.
module tb_fifo_wr_arbiter;

  localparam int NS = 2;
  localparam int DW = 64;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             srst_n;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0]    s_valid;
  logic [NS-1:0]    s_last;
  logic [NS-1:0]    s_ready;
  logic [DW-1:0]    fifo_din;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic             fifo_prog_full;
  logic [0:0]       grant_id;
  logic             busy;
  logic             oversize_err;
  logic [NS*CW-1:0] pkt_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_SRC       (NS),
    .DATA_W        (DW),
    .MAX_PKT_WORDS (112),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .srst_n         (srst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .fifo_din       (fifo_din),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .grant_id       (grant_id),
    .busy           (busy),
    .oversize_err   (oversize_err),
    .pkt_count      (pkt_count)
  );

  int checks = 0;
  int errors = 0;

  logic [64:0] q0[$];
  logic [64:0] q1[$];
  logic [63:0] exp_q[$];
  int          gnt_q[$];
  int          gap_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Queue a packet of n beats base..base+n-1 on a source; last flag on the final beat.
  task automatic add_pkt(input int src, input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      if (src == 0) q0.push_back({(k == n - 1), base + 64'(k)});
      else          q1.push_back({(k == n - 1), base + 64'(k)});
    end
  endtask

  task automatic exp_pkt(input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 64'(k));
  endtask

  task automatic exp_gnt(input int gid, input int gap);
    gnt_q.push_back(gid);
    gap_q.push_back(gap);
  endtask

  // Bounded wait for all queued traffic to drain and the arbiter to go idle.
  task automatic wait_done(input string name, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !busy) && n < max_cyc);
    chk(name, 64'(n < max_cyc), 64'd1);
  endtask

  task automatic wait_exp_left(input string name, input int left, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != left && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'(left));
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    srst_n = 1'b1;
  endtask

  // Source drivers: a beat leaves its queue after a valid&ready handshake.
  initial begin
    logic acc0, acc1;
    logic [64:0] f0, f1;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      acc0 = s_valid[0] && s_ready[0];
      acc1 = s_valid[1] && s_ready[1];
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      f0 = (q0.size() > 0) ? q0[0] : '0;
      f1 = (q1.size() > 0) ? q1[0] : '0;
      s_valid        = {q1.size() > 0, q0.size() > 0};
      s_last         = {f1[64], f0[64]};
      s_data[63:0]   = f0[63:0];
      s_data[127:64] = f1[63:0];
    end
  end

  // Monitor: every FIFO write and every new grant is checked against the scoreboard.
  initial begin
    logic bprev;
    int idle, eg, egap;
    bprev = 1'b0;
    idle  = 0;
    forever begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got din 0x%0h, expected no write", fifo_din);
        end else begin
          chk("fifo_din", fifo_din, exp_q.pop_front());
        end
      end
      if (busy === 1'b1 && !bprev) begin
        if (gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got grant %0d, expected none", grant_id);
        end else begin
          eg   = gnt_q.pop_front();
          egap = gap_q.pop_front();
          chk("grant_id", 64'(grant_id), 64'(eg));
          if (egap >= 0) chk("idle_gap", 64'(idle), 64'(egap));
        end
        idle = 0;
      end else if (busy !== 1'b1) begin
        idle++;
      end
      bprev = (busy === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst_n         = 1'b0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_oversize", 64'(oversize_err), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    @(posedge clk);
    #1;
    srst_n = 1'b1;

    // 1: single 4-beat packet from src0
    add_pkt(0, 64'h10, 4);
    exp_pkt(64'h10, 4);
    exp_gnt(0, -1);
    wait_done("t1_done", 50);
    chk("t1_pkt0", 64'(pkt_count[15:0]), 64'd1);

    // 2: both sources streaming 2-beat packets, fresh reset so src0 wins first
    do_reset();
    add_pkt(0, 64'h20, 2); add_pkt(0, 64'h22, 2);
    add_pkt(1, 64'h30, 2); add_pkt(1, 64'h32, 2);
    exp_pkt(64'h20, 2); exp_pkt(64'h30, 2); exp_pkt(64'h22, 2); exp_pkt(64'h32, 2);
    exp_gnt(0, -1); exp_gnt(1, 1); exp_gnt(0, 1); exp_gnt(1, 1);
    wait_done("t2_done", 60);
    chk("t2_pkt0", 64'(pkt_count[15:0]), 64'd2);
    chk("t2_pkt1", 64'(pkt_count[31:16]), 64'd2);

    // 3: prog_full blocks new grants; single-beat packets once released
    fifo_prog_full = 1'b1;
    add_pkt(0, 64'h40, 1);
    add_pkt(1, 64'h50, 1);
    exp_pkt(64'h40, 1); exp_pkt(64'h50, 1);
    exp_gnt(0, -1); exp_gnt(1, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t3_blocked_busy", 64'(busy), 64'd0);
    chk("t3_blocked_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    fifo_prog_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t3_grant_next", 64'(busy), 64'd1);
    wait_done("t3_done", 40);
    chk("t3_pkt0", 64'(pkt_count[15:0]), 64'd3);
    chk("t3_pkt1", 64'(pkt_count[31:16]), 64'd3);

    // 4: fifo_full stalls mid-packet for 3 cycles; prog_full mid-packet ignored
    add_pkt(0, 64'h60, 6);
    exp_pkt(64'h60, 6);
    exp_gnt(0, -1);
    wait_exp_left("t4_three_written", 3, 40);
    fifo_full      = 1'b1;
    fifo_prog_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_full_ready", 64'(s_ready), 64'd0);
      chk("t4_full_wr_en", 64'(fifo_wr_en), 64'd0);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_done("t4_done", 40);
    fifo_prog_full = 1'b0;
    chk("t4_pkt0", 64'(pkt_count[15:0]), 64'd4);

    // 5: max-length packet is fine, 114-beat packet sets sticky oversize_err
    do_reset();
    add_pkt(1, 64'h1000, 112);
    exp_pkt(64'h1000, 112);
    exp_gnt(1, -1);
    wait_done("t5a_done", 300);
    chk("t5a_oversize", 64'(oversize_err), 64'd0);
    chk("t5a_pkt1", 64'(pkt_count[31:16]), 64'd1);
    add_pkt(1, 64'h2000, 114);
    exp_pkt(64'h2000, 114);
    exp_gnt(1, -1);
    wait_done("t5b_done", 300);
    chk("t5b_oversize", 64'(oversize_err), 64'd1);
    chk("t5b_pkt1", 64'(pkt_count[31:16]), 64'd2);
    add_pkt(1, 64'h3000, 1);
    exp_pkt(64'h3000, 1);
    exp_gnt(1, -1);
    wait_done("t5c_done", 40);
    chk("t5c_sticky", 64'(oversize_err), 64'd1);

    // 6: reset during beat 2 of 5 drops the grant; src0 wins first afterwards
    add_pkt(0, 64'h70, 5);
    exp_pkt(64'h70, 5);
    exp_gnt(0, -1);
    wait_exp_left("t6_one_written", 4, 40);
    srst_n = 1'b0;
    q0.delete();
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("t6_rst_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_oversize", 64'(oversize_err), 64'd0);
    chk("t6_pkt_count", 64'(pkt_count), 64'd0);
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    add_pkt(0, 64'h80, 1);
    add_pkt(1, 64'h90, 1);
    exp_pkt(64'h80, 1); exp_pkt(64'h90, 1);
    exp_gnt(0, -1); exp_gnt(1, 1);
    wait_done("t6_done", 40);
    chk("t6_pkt0", 64'(pkt_count[15:0]), 64'd1);
    chk("t6_pkt1", 64'(pkt_count[31:16]), 64'd1);

    repeat (3) @(posedge clk);
    chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("end_gnt_empty", 64'(gnt_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
